// File: rtl/sliding_window.sv
// sliding_window
//   Turns a raster-order pixel stream of one Ni x Ni frame into vertical
//   tap columns of K pixels each. A column is one pixel from each of the
//   K most recent rows. This is the row-direction half of a KxK convolution
//   window. K-1 chained line buffers, each Ni pixels deep, delay the stream
//   by exactly one row per buffer.
//
// Ports
//   clk        sole clock, rising edge
//   rst        asynchronous active-high reset
//   start      single-cycle frame start request (honoured in IDLE only)
//   din_valid  din carries a pixel this cycle (accepted only in RUN)
//   din        signed pixel, row-major raster order
//   taps       tap column; top slot = oldest row r-K+1, bottom slot = row r
//   tvalid     one-cycle pulse: taps holds a complete column (r >= K-1)
//   tcol       column index c of the current taps
//   busy       frame in progress (RUN or DONE)
//   done       single-cycle frame-complete pulse
module sliding_window #(
  parameter int K  = 5,
  parameter int Ni = 28,
  parameter int DW = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 din_valid,
  input  logic signed [DW-1:0] din,
  output logic [K*DW-1:0]      taps,
  output logic                 tvalid,
  output logic [9:0]           tcol,
  output logic                 busy,
  output logic                 done
);

  localparam int CW = (Ni > 1) ? $clog2(Ni) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CW-1:0]    r_col;
  logic [CW-1:0]    r_row;
  logic [K*DW-1:0]  r_taps;
  logic             r_tvalid;
  logic [9:0]       r_tcol;

  logic             w_accept;
  logic             w_last;
  logic [K*DW-1:0]  w_tap_col;
  logic [DW-1:0]    w_lb_in  [K-1];
  logic [DW-1:0]    w_lb_out [K-1];

  assign w_accept = (r_state == S_RUN) && din_valid;
  assign w_last   = (r_col == CW'(Ni-1)) && (r_row == CW'(Ni-1));

  // Line buffers. Buffer gi delays the stream by (gi+1)*Ni accepted pixels
  // at its output, i.e. it presents the same column gi+1 rows earlier.
  // Contents survive across frames; rows r < K-1 are masked by tvalid.
  genvar gi;
  generate
    for (gi = 0; gi < K-1; gi++) begin : g_line
      logic [DW-1:0] r_line [Ni];

      if (gi == 0) begin : g_head
        assign w_lb_in[gi] = din;
      end else begin : g_chain
        assign w_lb_in[gi] = w_lb_out[gi-1];
      end

      assign w_lb_out[gi] = r_line[Ni-1];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int k = 0; k < Ni; k++) begin
            r_line[k] <= '0;
          end
        end else if (w_accept) begin
          r_line[0] <= w_lb_in[gi];
          for (int k = 1; k < Ni; k++) begin
            r_line[k] <= r_line[k-1];
          end
        end
      end
    end
  endgenerate

  // Column assembly: the buffer outputs are sampled before the shift, so
  // they still hold the pixels exactly 1..K-1 rows above the incoming one.
  assign w_tap_col[DW-1:0] = din;
  generate
    for (gi = 1; gi < K; gi++) begin : g_tap
      assign w_tap_col[gi*DW +: DW] = w_lb_out[gi-1];
    end
  endgenerate

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and state-decoded outputs
  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (w_accept && w_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        busy         = 1'b1;
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Position counters and registered tap outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col    <= '0;
      r_row    <= '0;
      r_taps   <= '0;
      r_tvalid <= 1'b0;
      r_tcol   <= '0;
    end else begin
      if (r_state == S_IDLE && start) begin
        r_col <= '0;
        r_row <= '0;
      end else if (w_accept) begin
        if (r_col == CW'(Ni-1)) begin
          r_col <= '0;
          r_row <= (r_row == CW'(Ni-1)) ? '0 : r_row + CW'(1);
        end else begin
          r_col <= r_col + CW'(1);
        end
      end

      r_tvalid <= w_accept && (r_row >= CW'(K-1));

      if (w_accept) begin
        r_taps <= w_tap_col;
        r_tcol <= 10'(r_col);
      end
    end
  end

  assign taps   = r_taps;
  assign tvalid = r_tvalid;
  assign tcol   = r_tcol;

endmodule

// File: tb/tb_sliding_window.sv
// tb_sliding_window
//   Directed frames through sliding_window (K=5, Ni=28, DW=32): plain
//   ramp, ramp with ~50% din_valid duty, negated ramp, ignored mid-frame
//   start, reset mid-frame, then a fresh frame. Pixel n of a frame is
//   value n (or -n), so the column for pixel n is n, n-28, ..., n-112.
module tb_sliding_window;

  localparam int K  = 5;
  localparam int NI = 28;
  localparam int DW = 32;
  localparam int NPIX = NI * NI;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic                 din_valid;
  logic signed [DW-1:0] din;
  logic [K*DW-1:0]      taps;
  logic                 tvalid;
  logic [9:0]           tcol;
  logic                 busy;
  logic                 done;

  int checks_cnt = 0;
  int errors_cnt = 0;

  sliding_window #(.K(K), .Ni(NI), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .din_valid (din_valid),
    .din       (din),
    .taps      (taps),
    .tvalid    (tvalid),
    .tcol      (tcol),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [K*DW-1:0] got,
                           input logic [K*DW-1:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] pix(input bit neg, input int n);
    return neg ? DW'(-n) : DW'(n);
  endfunction

  function automatic logic [K*DW-1:0] exp_taps(input bit neg, input int n);
    logic [K*DW-1:0] e;
    e = '0;
    for (int j = 0; j < K; j++) begin
      e[j*DW +: DW] = pix(neg, n - NI*j);
    end
    return e;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_taps"},   taps,   '0);
    check_val({tag, "_tvalid"}, K*DW'(tvalid), '0);
    check_val({tag, "_tcol"},   K*DW'(tcol),   '0);
    check_val({tag, "_busy"},   K*DW'(busy),   '0);
    check_val({tag, "_done"},   K*DW'(done),   '0);
  endtask

  // One frame. rnd: ~50% din_valid duty. restart_at: pixel index where
  // start is also pulsed. abort_after: assert rst after this many pixels.
  task automatic run_frame(input string name, input bit neg, input bit rnd,
                           input int restart_at, input int abort_after);
    int n;
    int cycles;
    int vcnt;
    int dcnt;
    bit v;
    bit last_ok;
    int r;
    int c;

    n = 0; cycles = 0; vcnt = 0; dcnt = 0; last_ok = 0;

    start = 1'b1;
    din_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    check_val({name, "_busy_after_start"}, K*DW'(busy), K*DW'(1));
    check_val({name, "_tvalid_after_start"}, K*DW'(tvalid), '0);

    while (n < NPIX) begin
      if (cycles > 20 * NPIX) begin
        check_val({name, "_frame_timeout"}, K*DW'(n), K*DW'(NPIX));
        return;
      end
      cycles++;
      v = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      din_valid = v;
      din = pix(neg, n);
      start = (n == restart_at);
      @(posedge clk); #1;
      start = 1'b0;
      if (tvalid) vcnt++;
      if (done)   dcnt++;
      if (v) begin
        r = n / NI;
        c = n % NI;
        check_val($sformatf("%s_tvalid_p%0d", name, n), K*DW'(tvalid),
                  K*DW'(r >= K-1));
        if (r >= K-1) begin
          check_val($sformatf("%s_taps_p%0d", name, n), taps, exp_taps(neg, n));
          check_val($sformatf("%s_tcol_p%0d", name, n), K*DW'(tcol), K*DW'(c));
        end
        check_val($sformatf("%s_done_p%0d", name, n), K*DW'(done),
                  K*DW'(n == NPIX-1));
        last_ok = (r >= K-1);
        n++;
        if (n == abort_after) begin
          din_valid = 1'b0;
          rst = 1'b1;
          #1;
          check_reset_outputs({name, "_in_reset"});
          @(posedge clk); #1;
          check_reset_outputs({name, "_in_reset_2"});
          rst = 1'b0;
          return;
        end
      end else begin
        check_val($sformatf("%s_stall_tvalid_%0d", name, n), K*DW'(tvalid), '0);
        check_val($sformatf("%s_stall_done_%0d", name, n), K*DW'(done), '0);
        if (last_ok) begin
          check_val($sformatf("%s_hold_taps_%0d", name, n), taps,
                    exp_taps(neg, n-1));
          check_val($sformatf("%s_hold_tcol_%0d", name, n), K*DW'(tcol),
                    K*DW'((n-1) % NI));
        end
      end
    end

    check_val({name, "_busy_in_done"}, K*DW'(busy), K*DW'(1));
    din_valid = 1'b0;
    @(posedge clk); #1;
    if (done) dcnt++;
    check_val({name, "_busy_after_done"}, K*DW'(busy), '0);
    check_val({name, "_tvalid_count"}, K*DW'(vcnt), K*DW'((NI-K+1)*NI));
    check_val({name, "_done_count"}, K*DW'(dcnt), K*DW'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    din_valid = 1'b0;
    din = '0;
    #1;
    check_reset_outputs("por");
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // din_valid in IDLE is ignored
    din_valid = 1'b1;
    din = 32'h1234_5678;
    repeat (3) @(posedge clk);
    #1;
    check_val("idle_ignore_tvalid", K*DW'(tvalid), '0);
    check_val("idle_ignore_busy", K*DW'(busy), '0);
    check_val("idle_ignore_taps", taps, '0);
    din_valid = 1'b0;

    run_frame("plain", 1'b0, 1'b0, -1, -1);

    // Hand-computed columns for the plain ramp (frame left them in place)
    check_val("plain_last_taps", taps,
              {32'd671, 32'd699, 32'd727, 32'd755, 32'd783});
    check_val("plain_last_tcol", K*DW'(tcol), K*DW'(27));

    run_frame("random", 1'b0, 1'b1, -1, -1);
    run_frame("neg", 1'b1, 1'b0, -1, -1);
    check_val("neg_last_taps", taps,
              {-32'sd671, -32'sd699, -32'sd727, -32'sd755, -32'sd783});
    run_frame("restart", 1'b0, 1'b0, 300, -1);
    run_frame("abort", 1'b0, 1'b0, -1, 501);

    repeat (3) begin
      @(posedge clk); #1;
      check_val("post_abort_done", K*DW'(done), '0);
      check_val("post_abort_busy", K*DW'(busy), '0);
    end

    run_frame("fresh", 1'b0, 1'b0, -1, -1);

    // Explicit single-pixel checks: (3,27) masked, (4,0) and neg (4,1)
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 0; n < 5*NI; n++) begin
      din_valid = 1'b1;
      din = (n < 4*NI + 1) ? pix(1'b0, n) : pix(1'b1, n);
      @(posedge clk); #1;
      if (n == 111) begin
        check_val("dir_p111_tvalid", K*DW'(tvalid), '0);
      end
      if (n == 112) begin
        check_val("dir_p112_taps", taps, {32'd0, 32'd28, 32'd56, 32'd84, 32'd112});
        check_val("dir_p112_tcol", K*DW'(tcol), '0);
        check_val("dir_p112_tvalid", K*DW'(tvalid), K*DW'(1));
      end
    end
    din_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;

    // Negated frame: pixel (4,1) must give {-1,-29,-57,-85,-113}
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 0; n <= 4*NI + 1; n++) begin
      din_valid = 1'b1;
      din = pix(1'b1, n);
      @(posedge clk); #1;
    end
    din_valid = 1'b0;
    check_val("dir_neg_p113_taps", taps,
              {-32'sd1, -32'sd29, -32'sd57, -32'sd85, -32'sd113});
    check_val("dir_neg_p113_tcol", K*DW'(tcol), K*DW'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
    $finish;
  end

endmodule

// File: doc/sliding_window.md
SLIDING_WINDOW -- requirements
Module: sliding_window

Interface
REQ-001 Parameter K, default 5: kernel height, i.e. rows per tap column.
REQ-002 Parameter Ni, default 28: square input frame width and height (28 for layer 1, 12 for layer 2).
REQ-003 Parameter DW, default 32: signed pixel width.
REQ-004 clk  input  1  sole clock; all logic on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  single-cycle frame start request.
REQ-007 din_valid  input  1  din carries a pixel this cycle.
REQ-008 din  input  DW  signed pixel, raster order (row-major, column 0 first).
REQ-009 taps  output  K*DW  one vertical tap column; taps[K*DW-1 -: DW] is the oldest row (r-K+1), taps[DW-1:0] is the current row r.
REQ-010 tvalid  output  1  taps holds a complete column (r >= K-1).
REQ-011 tcol  output  10  column index c of the current taps.
REQ-012 busy  output  1  frame in progress.
REQ-013 done  output  1  single-cycle frame-complete pulse.

Function
REQ-014 The block SHALL have the states IDLE, RUN and DONE.
REQ-015 IDLE -> RUN on start; RUN -> DONE on acceptance of pixel (Ni-1, Ni-1); DONE -> IDLE unconditionally after one cycle.
REQ-016 A pixel SHALL be accepted only in RUN with din_valid=1; din_valid outside RUN SHALL be ignored.
REQ-017 start SHALL be ignored in RUN and DONE, and SHALL take effect in IDLE only.
REQ-018 Counters col and row (0..Ni-1) SHALL both clear on the IDLE->RUN transition; col SHALL advance per accepted pixel and wrap Ni-1 -> 0, incrementing row.
REQ-019 Storage SHALL be K-1 chained line buffers, each an Ni-deep shift register that advances only on an accepted pixel; buffer i output feeds buffer i+1 input.
REQ-020 One cycle after pixel (r,c) is accepted: taps = {p(r-K+1,c), ..., p(r-1,c), p(r,c)}, tcol = c, tvalid = 1 iff r >= K-1.
REQ-021 tvalid SHALL be a one-cycle pulse per accepted pixel; taps and tcol SHALL hold between accepted pixels.
REQ-022 Pixels SHALL pass through bit-exact: no arithmetic, no sign change, no saturation.
REQ-023 Line buffers SHALL NOT be cleared between frames; stale rows are masked because tvalid=0 for r < K-1.
REQ-024 done SHALL be 1 exactly in the DONE cycle, coincident with the final tvalid pulse.
REQ-025 busy SHALL be 1 in RUN and DONE, and 0 in IDLE.
REQ-026 Each frame SHALL yield exactly (Ni-K+1)*Ni tvalid pulses, including columns c > Ni-K that the consumer discards.
REQ-027 din_valid may deassert at any point in a frame; the block SHALL stall with no state loss and SHALL impose no throughput limit (one pixel per cycle).

Reset
REQ-028 When rst asserts, the block SHALL immediately enter IDLE and clear col, row and all line buffers to 0.
REQ-029 Output reset values: taps=0, tvalid=0, tcol=0, busy=0, done=0.
REQ-030 Reset mid-frame SHALL abandon the frame with no done pulse; the next start SHALL begin a fresh frame at (0,0).

Verification
REQ-031 Setup: Ni=28, K=5, start then 784 consecutive pixels p(r,c)=r*28+c. Pixel (3,27)=111 accepted -> next cycle tvalid=0. Pixel (4,0)=112 -> taps={0,28,56,84,112}, tcol=0, tvalid=1.
REQ-032 Same frame, last pixel 783 accepted -> next cycle taps={671,699,727,755,783}, tcol=27, tvalid=1, done=1, busy=1; following cycle busy=0. Total tvalid count = 672.
REQ-033 Same frame with din_valid pseudo-random ~50% duty -> taps sequence identical to REQ-031/032, tvalid count 672, exactly one done pulse.
REQ-034 Negative pixels -(r*28+c) -> taps bit-exact two's complement; pixel (4,1) gives taps={-1,-29,-57,-85,-113}.
REQ-035 start pulsed at pixel 300 of a frame -> ignored; frame completes normally with done after pixel 783.
REQ-036 rst asserted after pixel 500, then start and a new frame -> outputs zero during reset, no done for the aborted frame; new frame output matches REQ-031/032 exactly.
